fft16_ctrl: RTL

Sequencing controller for the 16-point radix-2 FFT core. It accepts serial complex samples into the input register bank, fires the write-enable of the 16-word complex frame buffer to capture the frame, then steps the butterfly datapath through its 4 stages, writing each stage result back through the same buffer. It finally drains the 16 results out serially over a valid/ready handshake. It holds no sample data; it only drives indices, strobes and mux selects.

---
 rtl/fft16_pkg.sv | 24 ++
 rtl/fft16_stage_timer.sv | 67 ++++++
 rtl/fft16_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fft16_pkg.sv
// fft16_pkg: shared sizes, FSM state encoding and index helpers for the FFT16 sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft16_pkg;

  localparam int N       = 16;
  localparam int LOG2N   = 4;
  localparam int NSTAGES = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LATCH,
    STAGE,
    DRAIN
  } state_t;

  // Reverse the 4 index bits so a linear drain counter walks the
  // decimation-in-time buffer in natural spectral order.
  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft16_stage_timer.sv
// fft16_stage_timer: per-stage settle counter plus stage counter for the butterfly pass.
// Latency: writeback lands STAGE_LAT cycles after each stage starts; o_wb_nxt predicts it one cycle early.
// Backpressure: none; runs freely while i_run is high and holds cleared otherwise.
//
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_run           controller is in its STAGE state this cycle
//   o_wb            this cycle is a writeback cycle
//   o_wb_nxt        next cycle will be a writeback cycle (feeds registered strobes)
//   o_stage         active stage 0..3 (registered)
//   o_last_stage    o_stage is the final stage
module fft16_stage_timer
  import fft16_pkg::*;
#(
  parameter int STAGE_LAT = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  output logic       o_wb,
  output logic       o_wb_nxt,
  output logic [1:0] o_stage,
  output logic       o_last_stage
);

  localparam logic [3:0] LAT  = 4'(STAGE_LAT);
  localparam logic [1:0] LAST = 2'(NSTAGES - 1);

  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [1:0] r_stage;
  logic [1:0] w_stage_nxt;

  // Within a stage the counter runs 0..LAT; LAT itself is the writeback
  // cycle. Outside STAGE both counters sit at zero, so the stage number
  // returns to 0 only at the stage-3 exit and never wraps elsewhere.
  always_comb begin
    w_cnt_nxt   = 4'd0;
    w_stage_nxt = 2'd0;
    if (i_run) begin
      if (r_cnt == LAT) begin
        w_cnt_nxt   = 4'd0;
        w_stage_nxt = (r_stage == LAST) ? 2'd0 : r_stage + 2'd1;
      end else begin
        w_cnt_nxt   = r_cnt + 4'd1;
        w_stage_nxt = r_stage;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= 4'd0;
      r_stage <= 2'd0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  // LAT >= 1, so a cleared counter can never look like a writeback.
  assign o_wb         = i_run && (r_cnt == LAT);
  assign o_wb_nxt     = (w_cnt_nxt == LAT);
  assign o_stage      = r_stage;
  assign o_last_stage = (r_stage == LAST);

endmodule

// File: rtl/fft16_ctrl.sv
// fft16_ctrl: load / capture / 4-stage butterfly / drain sequencer for the 16-point FFT core.
// Latency: LATCH 1 cycle after slot-15 accept, first result 2+4*(STAGE_LAT+1) cycles after it.
// Backpressure: i_out_ready low stalls DRAIN with index held; o_in_ready low outside IDLE/LOAD.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_in_valid / o_in_ready      serial sample handshake
//   o_load_we, o_load_idx        input-bank write strobe (combinational) and slot
//   o_ram_we, o_src_sel          frame-buffer capture strobe and input mux select
//   o_stage                      active butterfly stage
//   o_out_valid / i_out_ready    result handshake, o_out_idx selects the buffer slot
//   o_busy, o_frame_done         not-idle flag and end-of-frame pulse
module fft16_ctrl
  import fft16_pkg::*;
#(
  parameter int STAGE_LAT  = 2,
  parameter bit BITREV_OUT = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic       o_load_we,
  output logic [3:0] o_load_idx,
  output logic       o_ram_we,
  output logic       o_src_sel,
  output logic [1:0] o_stage,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [3:0] o_out_idx,
  output logic       o_busy,
  output logic       o_frame_done
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_load_cnt;
  logic [3:0] w_load_cnt_nxt;
  logic [3:0] r_drain_cnt;
  logic [3:0] w_drain_cnt_nxt;
  logic       w_frame_done_nxt;

  logic       r_in_ready;
  logic       r_ram_we;
  logic       r_src_sel;
  logic       r_out_valid;
  logic [3:0] r_out_idx;
  logic       r_busy;
  logic       r_frame_done;

  logic       w_in_acc;
  logic       w_out_acc;
  logic       w_run;
  logic       w_wb;
  logic       w_wb_nxt;
  logic       w_last_stage;
  logic [1:0] w_stage;

  assign w_in_acc  = i_in_valid & r_in_ready;
  assign w_out_acc = r_out_valid & i_out_ready;
  assign w_run     = (r_state == STAGE);

  fft16_stage_timer #(
    .STAGE_LAT (STAGE_LAT)
  ) u_stage_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_run        (w_run),
    .o_wb         (w_wb),
    .o_wb_nxt     (w_wb_nxt),
    .o_stage      (w_stage),
    .o_last_stage (w_last_stage)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_load_cnt_nxt   = r_load_cnt;
    w_drain_cnt_nxt  = r_drain_cnt;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_in_acc) begin
          w_load_cnt_nxt = r_load_cnt + 4'd1;
          w_state_nxt    = LOAD;
        end
      end
      LOAD: begin
        if (w_in_acc) begin
          // The slot-15 accept wraps the counter back to 0 for the next frame.
          w_load_cnt_nxt = r_load_cnt + 4'd1;
          if (r_load_cnt == 4'd15) begin
            w_state_nxt = LATCH;
          end
        end
      end
      LATCH: begin
        w_state_nxt = STAGE;
      end
      STAGE: begin
        if (w_wb && w_last_stage) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_out_acc) begin
          w_drain_cnt_nxt = r_drain_cnt + 4'd1;
          if (r_drain_cnt == 4'd15) begin
            w_state_nxt      = IDLE;
            w_frame_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Every registered output is computed from the next state, so it is
  // already correct in the first cycle of that state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_load_cnt   <= 4'd0;
      r_drain_cnt  <= 4'd0;
      r_in_ready   <= 1'b1;
      r_ram_we     <= 1'b0;
      r_src_sel    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_idx    <= 4'd0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_load_cnt   <= w_load_cnt_nxt;
      r_drain_cnt  <= w_drain_cnt_nxt;
      r_in_ready   <= (w_state_nxt == IDLE) || (w_state_nxt == LOAD);
      r_ram_we     <= (w_state_nxt == LATCH) || w_wb_nxt;
      r_src_sel    <= w_wb_nxt;
      r_out_valid  <= (w_state_nxt == DRAIN);
      r_out_idx    <= BITREV_OUT ? bitrev4(w_drain_cnt_nxt) : w_drain_cnt_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_load_we    = w_in_acc;
  assign o_load_idx   = r_load_cnt;
  assign o_ram_we     = r_ram_we;
  assign o_src_sel    = r_src_sel;
  assign o_stage      = w_stage;
  assign o_out_valid  = r_out_valid;
  assign o_out_idx    = r_out_idx;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule
